// File: rtl/icache_pkg.sv
// Shared types and geometry for the instruction-cache refill path.
// Single cycle, combinational helpers only.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    FILL   = 2'd2,
    REPLAY = 2'd3
  } state_t;

  localparam int LINE_W = 128;
  localparam int TAG_W  = 25;
  localparam int IDX_W  = 3;
  localparam int OFF_W  = 2;
  localparam int WORD_W = 32;

  // Word offset plus the two byte-select bits are dropped to get the line base.
  function automatic logic [WORD_W-1:0] line_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Fetch, cache-fill and memory-request signals of the refill controller.
// Master is the controller side; slave is the fetch/cache/memory side.
interface icache_refill_ctrl_if;
  import icache_pkg::*;

  logic              cpu_req;
  logic [WORD_W-1:0] cpu_addr;
  logic              cache_hit;
  logic              cpu_stall;
  logic              fill_en;
  logic [WORD_W-1:0] fill_addr;
  logic [LINE_W-1:0] fill_line;
  logic              mem_req;
  logic [WORD_W-1:0] mem_addr;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_line;

  modport master (
    input  cpu_req, cpu_addr, cache_hit, mem_ack, mem_line,
    output cpu_stall, fill_en, fill_addr, fill_line, mem_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr, cache_hit, mem_ack, mem_line,
    input  cpu_stall, fill_en, fill_addr, fill_line, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_refill_ctrl_refill_timer.sv
// Clearable up-counter flagging the last permitted cycle of a memory wait.
// expired is combinational from the count; no backpressure.
module refill_timer #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // expired marks the MEM_TIMEOUT-th enabled cycle, so the wait lasts exactly that long.
  assign expired = en && (cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss handler: stalls fetch, fetches the 128-bit line, fills the cache and replays the lookup.
// Stall is 4 cycles minimum (miss, REQ, FILL, REPLAY); REQ waits for mem_ack up to MEM_TIMEOUT cycles.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  icache_refill_ctrl_if.master bus,
  output logic                 refill_err,
  output logic [CNT_W-1:0]     miss_count
);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic              miss;
  logic              stall;
  logic              expired;
  logic              in_req;

  assign in_req = (state == REQ);

  refill_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_req),
    .en      (in_req),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    stall     = 1'b1;
    miss      = 1'b0;
    case (state)
      IDLE: begin
        miss  = bus.cpu_req && !bus.cache_hit;
        stall = miss;
        if (miss) state_nxt = REQ;
      end
      REQ: begin
        // An ack landing on the expiry cycle still completes the refill.
        if (bus.mem_ack)  state_nxt = FILL;
        else if (expired) state_nxt = IDLE;
      end
      FILL:    state_nxt = REPLAY;
      REPLAY:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      line_q     <= '0;
      refill_err <= 1'b0;
      miss_count <= '0;
    end else begin
      state <= state_nxt;
      if (miss) begin
        addr_q <= line_align(bus.cpu_addr);
        if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
      end
      if (in_req && bus.mem_ack) line_q <= bus.mem_line;
      if (in_req && !bus.mem_ack && expired) refill_err <= 1'b1;
    end
  end

  assign bus.cpu_stall = stall;
  assign bus.mem_req   = in_req;
  assign bus.mem_addr  = addr_q;
  assign bus.fill_en   = (state == FILL);
  assign bus.fill_addr = addr_q;
  assign bus.fill_line = line_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench: dut_a uses default parameters, dut_b uses MEM_TIMEOUT=8, CNT_W=2.
module tb_icache_refill_ctrl;
  import icache_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         cache_hit;
  logic         mem_ack;
  logic [127:0] mem_line;

  logic         err_a, err_b;
  logic [15:0]  cnt_a;
  logic [1:0]   cnt_b;

  int tests = 0;
  int fails = 0;

  icache_refill_ctrl_if ifa ();
  icache_refill_ctrl_if ifb ();

  assign ifa.cpu_req   = cpu_req;
  assign ifa.cpu_addr  = cpu_addr;
  assign ifa.cache_hit = cache_hit;
  assign ifa.mem_ack   = mem_ack;
  assign ifa.mem_line  = mem_line;
  assign ifb.cpu_req   = cpu_req;
  assign ifb.cpu_addr  = cpu_addr;
  assign ifb.cache_hit = cache_hit;
  assign ifb.mem_ack   = mem_ack;
  assign ifb.mem_line  = mem_line;

  icache_refill_ctrl dut_a (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifa),
    .refill_err (err_a),
    .miss_count (cnt_a)
  );

  icache_refill_ctrl #(.MEM_TIMEOUT(8), .CNT_W(2)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifb),
    .refill_err (err_b),
    .miss_count (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cache_hit = 1'b0;
    mem_ack = 1'b0; mem_line = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_stall",   ifa.cpu_stall, 0);
    chk("rst_mem_req", ifa.mem_req, 0);
    chk("rst_fill_en", ifa.fill_en, 0);
    chk("rst_memaddr", ifa.mem_addr, 0);
    chk("rst_filladr", ifa.fill_addr, 0);
    chk("rst_count",   cnt_a, 0);
    chk("rst_err",     err_a, 0);

    // 1: hit, no refill activity
    cpu_req = 1'b1; cpu_addr = 32'h0000_0040; cache_hit = 1'b1;
    #1;
    chk("hit_stall", ifa.cpu_stall, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hit_mem_req", ifa.mem_req, 0);
      chk("hit_stall_n", ifa.cpu_stall, 0);
    end
    chk("hit_count", cnt_a, 0);

    // 2: cold miss, ack on first REQ cycle
    cpu_addr = 32'h0000_1234; cache_hit = 1'b0;
    #1;
    chk("cold_stall_miss", ifa.cpu_stall, 1);
    chk("cold_no_req_yet", ifa.mem_req, 0);
    step();
    mem_ack = 1'b1; mem_line = 128'h00000003_00000002_00000001_00000000;
    #1;
    chk("cold_mem_req",  ifa.mem_req, 1);
    chk("cold_mem_addr", ifa.mem_addr, 32'h0000_1230);
    chk("cold_stall_req", ifa.cpu_stall, 1);
    chk("cold_count",    cnt_a, 1);
    step();
    mem_ack = 1'b0; mem_line = '0;
    #1;
    chk("cold_fill_en",   ifa.fill_en, 1);
    chk("cold_fill_addr", ifa.fill_addr, 32'h0000_1230);
    chk("cold_fill_line", ifa.fill_line, 128'h00000003_00000002_00000001_00000000);
    chk("cold_stall_fill", ifa.cpu_stall, 1);
    chk("cold_req_low",   ifa.mem_req, 0);
    step();
    cache_hit = 1'b1;
    #1;
    chk("cold_stall_replay", ifa.cpu_stall, 1);
    chk("cold_fill_once",    ifa.fill_en, 0);
    step();
    chk("cold_stall_done", ifa.cpu_stall, 0);
    chk("cold_count_end",  cnt_a, 1);

    // 3: ack after 10 REQ cycles, cpu_addr wobbles meanwhile
    cpu_addr = 32'h0000_0080; cache_hit = 1'b0;
    step();
    cpu_addr = 32'h0000_0FF0;
    for (int i = 1; i <= 10; i++) begin
      chk("wob_mem_req",  ifa.mem_req, 1);
      chk("wob_mem_addr", ifa.mem_addr, 32'h0000_0080);
      if (i == 10) begin
        mem_ack = 1'b1; mem_line = 128'hAAAA;
      end
      step();
    end
    mem_ack = 1'b0;
    #1;
    chk("wob_fill_en",   ifa.fill_en, 1);
    chk("wob_fill_addr", ifa.fill_addr, 32'h0000_0080);
    chk("wob_fill_line", ifa.fill_line, 128'hAAAA);
    chk("wob_err",       err_a, 0);
    chk("wob_count",     cnt_a, 2);
    step();
    cache_hit = 1'b1;
    step();
    chk("wob_idle_stall", ifa.cpu_stall, 0);

    // 4: timeout on dut_b (MEM_TIMEOUT=8)
    rst = 1'b1; cpu_req = 1'b0;
    step();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h0000_0100; cache_hit = 1'b0;
    step();
    cpu_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("to_mem_req", ifb.mem_req, 1);
      chk("to_no_fill", ifb.fill_en, 0);
      step();
    end
    chk("to_req_drop", ifb.mem_req, 0);
    chk("to_err_set",  err_b, 1);
    chk("to_stall",    ifb.cpu_stall, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    #1;
    chk("late_ack_fill", ifb.fill_en, 0);
    chk("late_ack_req",  ifb.mem_req, 0);
    step();
    chk("late_ack_fill2", ifb.fill_en, 0);
    chk("to_err_sticky",  err_b, 1);

    // ack on the expiry cycle wins over the timeout
    cpu_req = 1'b1; cpu_addr = 32'h0000_0300; cache_hit = 1'b0;
    step();
    cpu_req = 1'b0;
    for (int i = 1; i < 8; i++) step();
    chk("edge_req_last", ifb.mem_req, 1);
    mem_ack = 1'b1; mem_line = 128'h5555;
    step();
    mem_ack = 1'b0;
    #1;
    chk("edge_fill_en",   ifb.fill_en, 1);
    chk("edge_fill_addr", ifb.fill_addr, 32'h0000_0300);
    chk("edge_fill_line", ifb.fill_line, 128'h5555);
    step(); step(); step();

    // 5: reset on the 3rd REQ cycle with ack during reset
    cpu_req = 1'b1; cpu_addr = 32'h0000_0200; cache_hit = 1'b0;
    step();
    cpu_req = 1'b0;
    step(); step();
    chk("mid_req3", ifa.mem_req, 1);
    rst = 1'b1; mem_ack = 1'b1; mem_line = 128'hDEAD;
    step();
    chk("mid_req_low", ifa.mem_req, 0);
    chk("mid_no_fill", ifa.fill_en, 0);
    chk("mid_count",   cnt_a, 0);
    chk("mid_err",     err_a, 0);
    chk("mid_err_b",   err_b, 0);
    rst = 1'b0; mem_ack = 1'b0; mem_line = '0;
    step();
    chk("mid_no_fill2", ifa.fill_en, 0);
    chk("mid_req_low2", ifa.mem_req, 0);

    // 6: saturation of the 2-bit counter on dut_b
    for (int k = 0; k < 5; k++) begin
      cpu_req = 1'b1; cpu_addr = 32'h0000_0400 + 32'(k * 16); cache_hit = 1'b0;
      step();
      cpu_req = 1'b0; mem_ack = 1'b1; mem_line = 128'(k + 1);
      #1;
      chk("sat_count", cnt_b, sat_exp[k]);
      step();
      mem_ack = 1'b0;
      #1;
      chk("sat_fill", ifb.fill_en, 1);
      step();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss handler and refill sequencer for the 8-line, 4-word direct-mapped instruction cache. Lines hold a 25-bit tag, 3-bit index and 2-bit word offset.
- Sits between the fetch stage, the cache array and a multi-cycle instruction memory.
- On a miss it stalls fetch, requests the 128-bit line from memory and writes it into the cache. It then replays the lookup, which replaces the fixed-delay self-refill inside the cache array.

Parameters:
- MEM_TIMEOUT, 64: maximum cycles to wait for mem_ack before aborting with an error.
- CNT_W, 16: width of the saturating miss counter.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  fetch stage presents cpu_addr this cycle.
- cpu_addr  in  32  byte address of the instruction.
- cache_hit  in  1  hit result from the cache for cpu_addr.
- cpu_stall  out  1  fetch must hold cpu_addr and retry.
- fill_en  out  1  one-cycle write strobe into the cache line.
- fill_addr  out  32  line-aligned address: {addr[31:4], 4'b0}.
- fill_line  out  128  line data to write; word0 in [31:0].
- mem_req  out  1  line read request to instruction memory.
- mem_addr  out  32  line-aligned request address.
- mem_ack  in  1  one-cycle pulse; mem_line is valid in the same cycle.
- mem_line  in  128  returned line data.
- refill_err  out  1  sticky flag: a timeout occurred.
- miss_count  out  CNT_W  saturating count of misses that started a refill.

Behaviour:
- Reset values:
  - All outputs 0 and state IDLE.
  - Latched address and line registers are cleared to 0.
  - refill_err and miss_count are cleared only by rst.
- States:
  - IDLE:
    - cpu_stall = cpu_req & ~cache_hit, combinational, same cycle.
    - On cpu_req & ~cache_hit: latch line address {cpu_addr[31:4],4'b0}, increment miss_count (holds at all-ones), go to REQ.
  - REQ:
    - mem_req=1, mem_addr=latched address; mem_req is registered and rises the cycle after the miss.
    - Timeout counter is cleared on entry.
    - mem_req stays high until mem_ack is sampled.
    - On mem_ack: capture mem_line, go to FILL.
    - If the counter reaches MEM_TIMEOUT with no ack: drop mem_req, set refill_err, go to IDLE. cpu_stall falls, and fetch re-detects the miss and retries.
  - FILL:
    - fill_en=1 for exactly one cycle, with fill_addr = latched address and fill_line = captured line.
    - mem_req=0. Go to REPLAY.
  - REPLAY:
    - cpu_stall=1 for one cycle while the cache re-evaluates the hit.
    - Go to IDLE, where the hit is evaluated normally.
- cpu_stall=1 in REQ, FILL and REPLAY regardless of cache_hit.
- Minimum miss penalty with mem_ack on the first REQ cycle: miss cycle + REQ + FILL + REPLAY = 4 cycles of cpu_stall. The hit is seen in the following IDLE cycle.
- cpu_addr changes while not in IDLE are ignored; the latched address is authoritative.
- cpu_req low in IDLE: no stall, no action, and cache_hit is ignored.
- mem_ack received outside REQ, e.g. a late ack after a timeout or reset: ignored, no fill.
- rst mid-refill: next cycle the block is in IDLE with mem_req=0 and fill_en=0. A partially returned line is never written.
- mem_ack arriving in the same cycle as the timeout expiry: the ack wins and the block goes to FILL.
- fill_en is never asserted in two consecutive cycles.

Decomposition:
- Shared package icache_pkg holds:
  - the state enum (IDLE, REQ, FILL, REPLAY);
  - LINE_W=128, TAG_W=25, IDX_W=3, OFF_W=2 and WORD_W=32;
  - the function line_align(addr) returning {addr[31:4],4'b0}.
- One natural sub-module, refill_timer: clearable up-counter with an expiry compare against MEM_TIMEOUT, used for the REQ timeout.

Test Plan:
1. Reset then hit:
   - Stimulus: rst for 2 cycles, then cpu_req=1, cpu_addr=0x0000_0040, cache_hit=1.
   - Response: cpu_stall=0, mem_req never rises, miss_count=0.
2. Cold miss, immediate ack:
   - Stimulus: cpu_addr=0x0000_1234 with cache_hit=0; mem_ack on the first REQ cycle with mem_line=0x00000003_00000002_00000001_00000000.
   - Response: mem_addr=0x0000_1230; fill_en pulses one cycle with that line; cpu_stall high for 4 cycles; miss_count=1.
3. Delayed ack with address wobble:
   - Stimulus: miss at 0x0000_0080; mem_ack after 10 REQ cycles; cpu_addr changed to 0x0000_0FF0 during the wait.
   - Response: mem_req held high for 10 cycles; fill_addr=0x0000_0080; refill_err=0.
4. Timeout:
   - Stimulus: MEM_TIMEOUT=8, miss at 0x0000_0100, no ack.
   - Response: mem_req drops after 8 cycles; refill_err=1 and stays set; no fill_en. A late mem_ack one cycle later is ignored.
5. Reset mid-refill:
   - Stimulus: assert rst on the 3rd REQ cycle; mem_ack arrives during rst.
   - Response: next cycle mem_req=0, fill_en=0, miss_count=0, refill_err=0.
6. Counter saturation:
   - Stimulus: CNT_W=2 with 5 back-to-back misses, each acked.
   - Response: miss_count reads 1, 2, 3, 3, 3.
